// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the i2c arbiter
// ST_TOUT/ST_DRAIN are present only when I2C_ARB_TIMEOUT_EN is defined.
package i2c_pkg;

  typedef struct packed {
    logic [6:0] daddr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       wen;
  } i2c_cmd_t;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } i2c_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_WAIT_RSP = 3'd2
`ifdef I2C_ARB_TIMEOUT_EN
    ,
    ST_TOUT     = 3'd3,
    ST_DRAIN    = 3'd4
`endif
  } arb_state_e;

  localparam logic [7:0] I2C_TOUT_DATA = 8'hFF;

endpackage

// File: rtl/i2c_arb_rr_pick.sv
// rtl/i2c_arb_rr_pick.sv - combinational round-robin picker
// Scans from last_i+1 modulo N and returns the first set request.
module rr_pick #(
  parameter int N = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] winner_o,
  output logic         any_o
);

  always_comb begin
    logic [W-1:0] idx;
    idx      = '0;
    winner_o = '0;
    any_o    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(last_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o    = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_arb.sv
// rtl/i2c_arb.sv - round-robin arbiter sharing one i2c engine between N_REQ requesters
// Optional response watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arb
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_val_i,
  input  logic [N_REQ*7-1:0]       req_daddr_i,
  input  logic [N_REQ*8-1:0]       req_addr_i,
  input  logic [N_REQ*8-1:0]       req_data_i,
  input  logic [N_REQ-1:0]         req_wen_i,
  output logic [N_REQ-1:0]         req_rdy_o,
  output logic [N_REQ-1:0]         rsp_val_o,
  output logic                     rsp_err_o,
  output logic [7:0]               rsp_data_o,
  input  logic [N_REQ-1:0]         rsp_rdy_i,
  output logic                     in_val_o,
  output logic [6:0]               in_daddr_o,
  output logic [7:0]               in_addr_o,
  output logic [7:0]               in_data_o,
  output logic                     in_wen_o,
  input  logic                     in_rdy_i,
  input  logic                     out_val_i,
  input  logic                     out_err_i,
  input  logic [7:0]               out_data_i,
  output logic                     out_rdy_o,
  output logic [$clog2(N_REQ)-1:0] grant_o,
  output logic                     busy_o
);

  localparam int GW = $clog2(N_REQ);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick_win;
  logic          pick_any;
  i2c_cmd_t      cmd_a [N_REQ];
  i2c_cmd_t      cmd_sel;
  i2c_rsp_t      eng_rsp;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0]   cnt_q, cnt_d;
`endif

  for (genvar i = 0; i < N_REQ; i++) begin : g_cmd
    assign cmd_a[i] = {req_daddr_i[i*7 +: 7], req_addr_i[i*8 +: 8],
                       req_data_i[i*8 +: 8], req_wen_i[i]};
  end

  assign cmd_sel = cmd_a[grant_q];
  assign eng_rsp = {out_err_i, out_data_i};

  rr_pick #(.N(N_REQ)) u_pick (
    .req_i    (req_val_i),
    .last_i   (last_q),
    .winner_o (pick_win),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_win;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A withdrawn request abandons the grant without touching last.
        if (!req_val_i[grant_q]) begin
          state_d = ST_IDLE;
        end else if (in_rdy_i) begin
          state_d = ST_WAIT_RSP;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_WAIT_RSP: begin
        if (out_val_i && rsp_rdy_i[grant_q]) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
        end else if (!out_val_i && cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_TOUT;
        end else begin
          cnt_d   = cnt_q + 32'd1;
`endif
        end
      end
`ifdef I2C_ARB_TIMEOUT_EN
      ST_TOUT: begin
        if (rsp_rdy_i[grant_q]) begin
          last_d  = grant_q;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_val_i) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_rdy_o  = '0;
    rsp_val_o  = '0;
    rsp_err_o  = 1'b0;
    rsp_data_o = '0;
    in_val_o   = 1'b0;
    in_daddr_o = '0;
    in_addr_o  = '0;
    in_data_o  = '0;
    in_wen_o   = 1'b0;
    out_rdy_o  = 1'b0;
    grant_o    = grant_q;
    busy_o     = (state_q != ST_IDLE);
    case (state_q)
      ST_ISSUE: begin
        in_val_o           = req_val_i[grant_q];
        in_daddr_o         = cmd_sel.daddr;
        in_addr_o          = cmd_sel.addr;
        in_data_o          = cmd_sel.data;
        in_wen_o           = cmd_sel.wen;
        req_rdy_o[grant_q] = in_rdy_i;
      end
      ST_WAIT_RSP: begin
        rsp_val_o[grant_q] = out_val_i;
        rsp_err_o          = eng_rsp.err;
        rsp_data_o         = eng_rsp.data;
        out_rdy_o          = rsp_rdy_i[grant_q];
      end
`ifdef I2C_ARB_TIMEOUT_EN
      ST_TOUT: begin
        rsp_val_o[grant_q] = 1'b1;
        rsp_err_o          = 1'b1;
        rsp_data_o         = I2C_TOUT_DATA;
      end
      ST_DRAIN: begin
        out_rdy_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_arb.sv
// tb/tb_i2c_arb.sv - directed self-checking bench for i2c_arb
// Timeout scenario runs only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_arb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_val_i;
  logic [13:0] req_daddr_i;
  logic [15:0] req_addr_i;
  logic [15:0] req_data_i;
  logic [1:0]  req_wen_i;
  logic [1:0]  req_rdy_o;
  logic [1:0]  rsp_val_o;
  logic        rsp_err_o;
  logic [7:0]  rsp_data_o;
  logic [1:0]  rsp_rdy_i;
  logic        in_val_o;
  logic [6:0]  in_daddr_o;
  logic [7:0]  in_addr_o;
  logic [7:0]  in_data_o;
  logic        in_wen_o;
  logic        in_rdy_i;
  logic        out_val_i;
  logic        out_err_i;
  logic [7:0]  out_data_i;
  logic        out_rdy_o;
  logic [0:0]  grant_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  i2c_arb #(.N_REQ(2), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_val_i(req_val_i), .req_daddr_i(req_daddr_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_wen_i(req_wen_i), .req_rdy_o(req_rdy_o),
    .rsp_val_o(rsp_val_o), .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o),
    .rsp_rdy_i(rsp_rdy_i),
    .in_val_o(in_val_o), .in_daddr_o(in_daddr_o), .in_addr_o(in_addr_o),
    .in_data_o(in_data_o), .in_wen_o(in_wen_o), .in_rdy_i(in_rdy_i),
    .out_val_i(out_val_i), .out_err_i(out_err_i), .out_data_i(out_data_i),
    .out_rdy_o(out_rdy_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive-only: one full transaction for requester idx, leaves arbiter in IDLE.
  task automatic run_txn(input int idx);
    req_val_i = 2'b01 << idx; in_rdy_i = 1'b1; rsp_rdy_i = 2'b01 << idx; out_val_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    req_val_i = 2'b00; out_val_i = 1'b1; out_err_i = 1'b0; out_data_i = 8'h00;
    @(negedge clk_i);
    out_val_i = 1'b0; in_rdy_i = 1'b0; rsp_rdy_i = 2'b00;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_val_i = '0; req_daddr_i = '0; req_addr_i = '0; req_data_i = '0;
    req_wen_i = '0; rsp_rdy_i = '0; in_rdy_i = 1'b0; out_val_i = 1'b0; out_err_i = 1'b0;
    out_data_i = '0;
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    vectors++;
    if ({busy_o, in_val_o, out_rdy_o, req_rdy_o, rsp_val_o, grant_o, rsp_err_o, rsp_data_o} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b in_val=%b out_rdy=%b req_rdy=%b rsp_val=%b grant=%b err=%b data=%h, expected all 0",
               busy_o, in_val_o, out_rdy_o, req_rdy_o, rsp_val_o, grant_o, rsp_err_o, rsp_data_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_single();
    bit seen;
    req_daddr_i[6:0] = 7'h20; req_addr_i[7:0] = 8'h14; req_data_i[7:0] = 8'hA5; req_wen_i[0] = 1'b1;
    req_val_i = 2'b01; in_rdy_i = 1'b1; rsp_rdy_i = 2'b01;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || in_val_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_grant_latency: got busy=%b in_val=%b, expected 0 0", busy_o, in_val_o);
    end
    @(negedge clk_i); #1;
    vectors++;
    if ({in_val_o, in_daddr_o, in_addr_o, in_data_o, in_wen_o, req_rdy_o, grant_o} !== {1'b1, 7'h20, 8'h14, 8'hA5, 1'b1, 2'b01, 1'b0}) begin
      miscompares++;
      $display("FAIL single_issue: got val=%b daddr=%h addr=%h data=%h wen=%b rdy=%b grant=%b, expected 1 20 14 a5 1 01 0",
               in_val_o, in_daddr_o, in_addr_o, in_data_o, in_wen_o, req_rdy_o, grant_o);
    end
    @(negedge clk_i);
    req_val_i = 2'b00; in_rdy_i = 1'b0;
    #1;
    vectors++;
    if (in_val_o !== 1'b0 || req_rdy_o !== 2'b00 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_wait_entry: got in_val=%b req_rdy=%b busy=%b, expected 0 00 1", in_val_o, req_rdy_o, busy_o);
    end
    seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i); #1;
      if (rsp_val_o !== 2'b00) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL single_no_early_rsp: got rsp_val during silence=1, expected 0");
    end
    out_val_i = 1'b1; out_err_i = 1'b0; out_data_i = 8'h00;
    #1;
    vectors++;
    if (rsp_val_o !== 2'b01 || rsp_err_o !== 1'b0 || out_rdy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_rsp: got rsp_val=%b err=%b out_rdy=%b, expected 01 0 1", rsp_val_o, rsp_err_o, out_rdy_o);
    end
    @(negedge clk_i);
    out_val_i = 1'b0; rsp_rdy_i = 2'b00;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || rsp_val_o !== 2'b00) begin
      miscompares++;
      $display("FAIL single_done: got busy=%b rsp_val=%b, expected 0 00", busy_o, rsp_val_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_contention();
    logic [1:0] exp_v;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    req_daddr_i = {7'h21, 7'h20}; req_addr_i = {8'h02, 8'h01}; req_data_i = {8'h22, 8'h11};
    req_wen_i = 2'b11; req_val_i = 2'b11; in_rdy_i = 1'b1; rsp_rdy_i = 2'b11; out_val_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_v = 2'(t % 2);
      #1;
      vectors++;
      if (req_rdy_o !== 2'b00) begin
        miscompares++;
        $display("FAIL contention_idle_rdy[%0d]: got %b, expected 00", t, req_rdy_o);
      end
      @(negedge clk_i); #1;
      vectors++;
      if ({1'b0, grant_o} !== exp_v || req_rdy_o !== (2'b01 << exp_v) ||
          in_daddr_o !== (exp_v[0] ? 7'h21 : 7'h20)) begin
        miscompares++;
        $display("FAIL contention_grant[%0d]: got grant=%b rdy=%b daddr=%h, expected grant=%0d rdy=%b daddr=%h",
                 t, grant_o, req_rdy_o, in_daddr_o, exp_v, 2'b01 << exp_v, exp_v[0] ? 7'h21 : 7'h20);
      end
      @(negedge clk_i);
      out_val_i = 1'b1;
      #1;
      vectors++;
      if (rsp_val_o !== (2'b01 << exp_v) || req_rdy_o !== 2'b00) begin
        miscompares++;
        $display("FAIL contention_rsp[%0d]: got rsp_val=%b req_rdy=%b, expected %b 00", t, rsp_val_o, req_rdy_o, 2'b01 << exp_v);
      end
      @(negedge clk_i);
      out_val_i = 1'b0;
      if (t == 3) req_val_i = 2'b00;
    end
    in_rdy_i = 1'b0; rsp_rdy_i = 2'b00;
    @(negedge clk_i);
  endtask

  task automatic test_read();
    int hs;
    req_daddr_i[13:7] = 7'h21; req_addr_i[15:8] = 8'h13; req_wen_i[1] = 1'b0;
    req_val_i = 2'b10; in_rdy_i = 1'b1; rsp_rdy_i = 2'b00;
    @(negedge clk_i); #1;
    vectors++;
    if ({grant_o, in_daddr_o, in_addr_o, in_wen_o} !== {1'b1, 7'h21, 8'h13, 1'b0}) begin
      miscompares++;
      $display("FAIL read_issue: got grant=%b daddr=%h addr=%h wen=%b, expected 1 21 13 0", grant_o, in_daddr_o, in_addr_o, in_wen_o);
    end
    @(negedge clk_i);
    req_val_i = 2'b00; in_rdy_i = 1'b0; out_val_i = 1'b1; out_err_i = 1'b0; out_data_i = 8'h3C;
    hs = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      vectors++;
      if (out_rdy_o !== 1'b0 || rsp_val_o !== 2'b10 || rsp_data_o !== 8'h3C) begin
        miscompares++;
        $display("FAIL read_hold[%0d]: got out_rdy=%b rsp_val=%b data=%h, expected 0 10 3c", k, out_rdy_o, rsp_val_o, rsp_data_o);
      end
      if (out_val_i && out_rdy_o) hs++;
      @(negedge clk_i);
    end
    rsp_rdy_i = 2'b10;
    #1;
    vectors++;
    if (out_rdy_o !== 1'b1 || rsp_data_o !== 8'h3C) begin
      miscompares++;
      $display("FAIL read_consume: got out_rdy=%b data=%h, expected 1 3c", out_rdy_o, rsp_data_o);
    end
    if (out_val_i && out_rdy_o) hs++;
    @(negedge clk_i);
    out_val_i = 1'b0; rsp_rdy_i = 2'b00;
    #1;
    vectors++;
    if (busy_o !== 1'b0 || hs !== 1) begin
      miscompares++;
      $display("FAIL read_handshakes: got busy=%b handshakes=%0d, expected 0 1", busy_o, hs);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid();
    run_txn(0);
    req_val_i = 2'b10; in_rdy_i = 1'b1; rsp_rdy_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i);
    req_val_i = 2'b00; in_rdy_i = 1'b0;
    #1;
    vectors++;
    if (busy_o !== 1'b1 || grant_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_waiting: got busy=%b grant=%b, expected 1 1", busy_o, grant_o);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; out_val_i = 1'b1; out_err_i = 1'b1; out_data_i = 8'h77; rsp_rdy_i = 2'b11;
    #1;
    vectors++;
    if ({busy_o, in_val_o, out_rdy_o, req_rdy_o, rsp_val_o, grant_o, rsp_err_o, rsp_data_o} !== 17'h0) begin
      miscompares++;
      $display("FAIL rstmid_outputs: got busy=%b in_val=%b out_rdy=%b req_rdy=%b rsp_val=%b grant=%b err=%b data=%h, expected all 0",
               busy_o, in_val_o, out_rdy_o, req_rdy_o, rsp_val_o, grant_o, rsp_err_o, rsp_data_o);
    end
    out_val_i = 1'b0; out_err_i = 1'b0; out_data_i = 8'h00; rsp_rdy_i = 2'b00;
    req_val_i = 2'b11;
    @(negedge clk_i); #1;
    vectors++;
    if (grant_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_priority: got grant=%b busy=%b, expected 0 1", grant_o, busy_o);
    end
    req_val_i = 2'b00;
    @(negedge clk_i);
  endtask

  task automatic test_withdraw();
    bit accepted;
    run_txn(0);
    req_val_i = 2'b10; in_rdy_i = 1'b0; accepted = 1'b0;
    @(negedge clk_i); #1;
    vectors++;
    if (grant_o !== 1'b1 || in_val_o !== 1'b1 || req_rdy_o !== 2'b00) begin
      miscompares++;
      $display("FAIL withdraw_issue: got grant=%b in_val=%b req_rdy=%b, expected 1 1 00", grant_o, in_val_o, req_rdy_o);
    end
    if (in_val_o && in_rdy_i) accepted = 1'b1;
    @(negedge clk_i);
    req_val_i = 2'b00;
    #1;
    vectors++;
    if (in_val_o !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_drop: got in_val=%b, expected 0", in_val_o);
    end
    if (in_val_o && in_rdy_i) accepted = 1'b1;
    @(negedge clk_i); #1;
    vectors++;
    if (busy_o !== 1'b0 || accepted !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_idle: got busy=%b accepted=%b, expected 0 0", busy_o, accepted);
    end
    req_val_i = 2'b11;
    @(negedge clk_i); #1;
    vectors++;
    if (grant_o !== 1'b1) begin
      miscompares++;
      $display("FAIL withdraw_last_kept: got grant=%b, expected 1", grant_o);
    end
    req_val_i = 2'b00;
    @(negedge clk_i);
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit early;
    req_val_i = 2'b01; in_rdy_i = 1'b1; rsp_rdy_i = 2'b00; out_val_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    req_val_i = 2'b00; in_rdy_i = 1'b0;
    early = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (rsp_val_o !== 2'b00 || busy_o !== 1'b1) early = 1'b1;
      @(negedge clk_i);
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL tout_early: got response before limit=1, expected 0");
    end
    #1;
    vectors++;
    if (rsp_val_o !== 2'b01 || rsp_err_o !== 1'b1 || rsp_data_o !== 8'hFF || out_rdy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tout_rsp: got rsp_val=%b err=%b data=%h out_rdy=%b, expected 01 1 ff 0", rsp_val_o, rsp_err_o, rsp_data_o, out_rdy_o);
    end
    rsp_rdy_i = 2'b01;
    @(negedge clk_i);
    rsp_rdy_i = 2'b00; out_val_i = 1'b1; out_data_i = 8'h55;
    #1;
    vectors++;
    if (rsp_val_o !== 2'b00 || out_rdy_o !== 1'b1 || in_val_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tout_drain: got rsp_val=%b out_rdy=%b in_val=%b, expected 00 1 0", rsp_val_o, out_rdy_o, in_val_o);
    end
    @(negedge clk_i);
    out_val_i = 1'b0; out_data_i = 8'h00;
    #1;
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL tout_idle: got busy=%b, expected 0", busy_o);
    end
    @(negedge clk_i);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_read();
    test_reset_mid();
    test_withdraw();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
